// File: rtl/alu_exec_ctrl_pkg.sv
// Shared types for the ALU execution controller: ALU function codes,
// controller states and the latched status-flag layout.
package alu_exec_ctrl_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    INV = 3'd5,
    SHL = 3'd6,
    SHR = 3'd7
  } alu_func_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERAND = 2'd1,
    EXEC    = 2'd2
  } exec_state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Field order matches the {V,C,N,Z} bit layout of status_flags.
  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } status_flags_t;

endpackage

// File: rtl/alu_exec_ctrl_reg_file.sv
// Register file: two registered read ports, a combinational debug port and one
// write port shared between ALU writeback (priority) and host writes.
module reg_file
  import alu_exec_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              host_en,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;

  // Read ports hold their last value so the ALU operands stay stable between commands.
  always_comb begin
    regs_d      = regs_q;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (wb_en) begin
      regs_d[wb_addr] = wb_data;
    end else if (host_en) begin
      regs_d[host_addr] = host_data;
    end
    if (rd_en) begin
      rd_data_a_d = regs_q[rd_addr_a];
      rd_data_b_d = regs_q[rd_addr_b];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q      <= '{default: '0};
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      regs_q      <= regs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequences one command at a time: operand fetch, execution on the external
// combinational alu, then register writeback and status-flag capture.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  alu_func_e         cmd_func,
  input  logic [REG_AW-1:0] cmd_rs_a,
  input  logic [REG_AW-1:0] cmd_rs_b,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic              cmd_wb_en,
  input  logic              host_wr_en,
  input  logic [REG_AW-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output alu_func_e         alu_func,
  output logic              output_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero_flag,
  input  logic              negative_flag,
  input  logic              carry_flag,
  input  logic              signed_overflow,
  output logic [3:0]        status_flags,
  output logic              done,
  input  logic [REG_AW-1:0] rd_dbg_addr,
  output logic [DATA_W-1:0] rd_dbg_data
);

  exec_state_e       state_q, state_d;
  alu_func_e         alu_func_q, alu_func_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wb_en_q, wb_en_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              output_enable_q, output_enable_d;
  logic              done_q, done_d;
  status_flags_t     flags_q, flags_d;
  logic              accept;
  logic              rf_wb_en;
  logic              rf_host_en;

  // A command accepted on the same edge as a host write wins; the host write is dropped.
  assign accept     = (state_q == IDLE) && cmd_valid;
  assign rf_wb_en   = (state_q == EXEC) && wb_en_q;
  assign rf_host_en = (state_q == IDLE) && host_wr_en && !accept;

  always_comb begin
    state_d         = state_q;
    alu_func_d      = alu_func_q;
    rd_d            = rd_q;
    wb_en_d         = wb_en_q;
    cmd_ready_d     = cmd_ready_q;
    output_enable_d = output_enable_q;
    done_d          = 1'b0;
    flags_d         = flags_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d     = OPERAND;
          alu_func_d  = cmd_func;
          rd_d        = cmd_rd;
          wb_en_d     = cmd_wb_en;
          cmd_ready_d = 1'b0;
        end
      end
      OPERAND: begin
        state_d         = EXEC;
        output_enable_d = 1'b1;
      end
      EXEC: begin
        state_d         = IDLE;
        output_enable_d = 1'b0;
        cmd_ready_d     = 1'b1;
        done_d          = 1'b1;
        flags_d         = '{v: signed_overflow, c: carry_flag,
                            n: negative_flag, z: zero_flag};
      end
      default: begin
        state_d         = IDLE;
        output_enable_d = 1'b0;
        cmd_ready_d     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      alu_func_q      <= ADD;
      rd_q            <= '0;
      wb_en_q         <= 1'b0;
      cmd_ready_q     <= 1'b1;
      output_enable_q <= 1'b0;
      done_q          <= 1'b0;
      flags_q         <= '0;
    end else begin
      state_q         <= state_d;
      alu_func_q      <= alu_func_d;
      rd_q            <= rd_d;
      wb_en_q         <= wb_en_d;
      cmd_ready_q     <= cmd_ready_d;
      output_enable_q <= output_enable_d;
      done_q          <= done_d;
      flags_q         <= flags_d;
    end
  end

  // Sources are read on the accept edge, so the operands are valid throughout OPERAND.
  reg_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (accept),
    .rd_addr_a (cmd_rs_a),
    .rd_addr_b (cmd_rs_b),
    .rd_data_a (operand_a),
    .rd_data_b (operand_b),
    .wb_en     (rf_wb_en),
    .wb_addr   (rd_q),
    .wb_data   (alu_result),
    .host_en   (rf_host_en),
    .host_addr (host_wr_addr),
    .host_data (host_wr_data),
    .dbg_addr  (rd_dbg_addr),
    .dbg_data  (rd_dbg_data)
  );

  assign cmd_ready     = cmd_ready_q;
  assign output_enable = output_enable_q;
  assign alu_func      = alu_func_q;
  assign done          = done_q;
  assign status_flags  = flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: a behavioural alu drives the result
// bus, and a register/flag reference model predicts every writeback.
module tb_alu_exec_ctrl;
  import alu_exec_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  alu_func_e  cmd_func;
  logic [1:0] cmd_rs_a, cmd_rs_b, cmd_rd;
  logic       cmd_wb_en;
  logic       host_wr_en;
  logic [1:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic [7:0] operand_a, operand_b;
  alu_func_e  alu_func;
  logic       output_enable;
  wire  [7:0] alu_bus;
  logic       zero_flag, negative_flag, carry_flag, signed_overflow;
  logic [3:0] status_flags;
  logic       done;
  logic [1:0] rd_dbg_addr;
  logic [7:0] rd_dbg_data;

  logic [11:0] alu_out;
  logic [7:0]  ref_regs [4];
  logic [3:0]  ref_flags;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_rs_a(cmd_rs_a), .cmd_rs_b(cmd_rs_b), .cmd_rd(cmd_rd), .cmd_wb_en(cmd_wb_en),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .operand_a(operand_a), .operand_b(operand_b), .alu_func(alu_func),
    .output_enable(output_enable), .alu_result(alu_bus),
    .zero_flag(zero_flag), .negative_flag(negative_flag),
    .carry_flag(carry_flag), .signed_overflow(signed_overflow),
    .status_flags(status_flags), .done(done),
    .rd_dbg_addr(rd_dbg_addr), .rd_dbg_data(rd_dbg_data)
  );

  // Returns {V,C,N,Z,result}; C is carry-out for ADD and borrow for SUB.
  function automatic logic [11:0] alu_ref(input alu_func_e f, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (f)
      ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[7:0];
        c = w[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      SUB: begin
        r = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      INV: r = ~a;
      SHL: begin r = {a[6:0], 1'b0}; c = a[7]; end
      SHR: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = 8'h00;
    endcase
    return {v, c, r[7], (r == 8'h00), r};
  endfunction

  always_comb alu_out = alu_ref(alu_func, operand_a, operand_b);
  assign alu_bus = output_enable ? alu_out[7:0] : 8'hzz;
  assign signed_overflow = alu_out[11];
  assign carry_flag      = alu_out[10];
  assign negative_flag   = alu_out[9];
  assign zero_flag       = alu_out[8];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    host_wr_en   = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    @(negedge clk);
    host_wr_en   = 1'b0;
    ref_regs[a]  = d;
  endtask

  // Issues one command at a negedge and returns at the negedge where done is seen.
  task automatic run_cmd(input alu_func_e f, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] d, input logic wb, input logic collide,
                         output int lat, output int low_cnt);
    logic [11:0] e;
    e = alu_ref(f, ref_regs[a], ref_regs[b]);
    cmd_valid = 1'b1; cmd_func = f; cmd_rs_a = a; cmd_rs_b = b; cmd_rd = d; cmd_wb_en = wb;
    if (collide) begin
      host_wr_en   = 1'b1;
      host_wr_addr = 2'($urandom);
      host_wr_data = 8'($urandom);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    host_wr_en = 1'b0;
    cmd_func  = alu_func_e'(3'($urandom_range(0, 7)));
    cmd_rs_a  = 2'($urandom); cmd_rs_b = 2'($urandom); cmd_rd = 2'($urandom);
    cmd_wb_en = 1'($urandom);
    lat = 1;
    low_cnt = 0;
    while (done !== 1'b1 && lat < 10) begin
      if (cmd_ready === 1'b0) low_cnt++;
      @(negedge clk);
      lat++;
    end
    if (wb) ref_regs[d] = e[7:0];
    ref_flags = e[11:8];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_func = SUB; cmd_rs_a = 2'd0; cmd_rs_b = 2'd0; cmd_rd = 2'd0;
    cmd_wb_en = 1'b0; host_wr_en = 1'b0; host_wr_addr = 2'd0; host_wr_data = 8'h00;
    rd_dbg_addr = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_flags = 4'h0;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (output_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_oe: got %b expected 0", output_enable); end
    n_cmp++; if (status_flags !== 4'h0) begin n_bad++; $display("[TB] FAIL reset_flags: got %b expected 0000", status_flags); end
    n_cmp++; if (operand_a !== 8'h00 || operand_b !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_operands: got %h/%h expected 00/00", operand_a, operand_b); end
    n_cmp++; if (alu_func !== ADD) begin n_bad++; $display("[TB] FAIL reset_func: got %0d expected %0d", alu_func, ADD); end
    for (int i = 0; i < 4; i++) begin
      rd_dbg_addr = 2'(i); #1;
      n_cmp++; if (rd_dbg_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_reg%0d: got %h expected 00", i, rd_dbg_data); end
    end
  endtask

  task automatic test_add_basic;
    int lat, low;
    @(negedge clk);
    host_write(2'd0, 8'h10);
    host_write(2'd1, 8'h20);
    run_cmd(ADD, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, lat, low);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("[TB] FAIL add_latency: got %0d expected 3", lat); end
    n_cmp++; if (low !== 2) begin n_bad++; $display("[TB] FAIL add_ready_low: got %0d expected 2", low); end
    n_cmp++; if (status_flags !== 4'b0000) begin n_bad++; $display("[TB] FAIL add_flags: got %b expected 0000", status_flags); end
    n_cmp++; if (operand_a !== 8'h10 || operand_b !== 8'h20 || alu_func !== ADD) begin n_bad++; $display("[TB] FAIL add_hold_ops: got %h/%h/%0d expected 10/20/0", operand_a, operand_b, alu_func); end
    rd_dbg_addr = 2'd2; #1;
    n_cmp++; if (rd_dbg_data !== 8'h30) begin n_bad++; $display("[TB] FAIL add_r2: got %h expected 30", rd_dbg_data); end
  endtask

  task automatic test_overflow;
    int lat, low;
    @(negedge clk);
    host_write(2'd0, 8'h7F);
    host_write(2'd1, 8'h01);
    run_cmd(ADD, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, lat, low);
    n_cmp++; if (status_flags !== 4'b1010) begin n_bad++; $display("[TB] FAIL ovf_flags: got %b expected 1010", status_flags); end
    rd_dbg_addr = 2'd3; #1;
    n_cmp++; if (rd_dbg_data !== 8'h80) begin n_bad++; $display("[TB] FAIL ovf_r3: got %h expected 80", rd_dbg_data); end
  endtask

  task automatic test_compare;
    int lat, low;
    @(negedge clk);
    host_write(2'd0, 8'h30);
    host_write(2'd1, 8'h30);
    run_cmd(SUB, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, lat, low);
    n_cmp++; if (status_flags !== 4'b0001) begin n_bad++; $display("[TB] FAIL cmp_flags: got %b expected 0001", status_flags); end
    for (int i = 0; i < 4; i++) begin
      rd_dbg_addr = 2'(i); #1;
      n_cmp++; if (rd_dbg_data !== ref_regs[i]) begin n_bad++; $display("[TB] FAIL cmp_reg%0d: got %h expected %h", i, rd_dbg_data, ref_regs[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, low;
    @(negedge clk);
    host_write(2'd0, 8'hAA);
    run_cmd(INV, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, lat, low);
    rd_dbg_addr = 2'd0; #1;
    n_cmp++; if (rd_dbg_data !== 8'h55) begin n_bad++; $display("[TB] FAIL b2b_first: got %h expected 55", rd_dbg_data); end
    n_cmp++; if (low !== 2) begin n_bad++; $display("[TB] FAIL b2b_ready_low1: got %0d expected 2", low); end
    run_cmd(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, lat, low);
    n_cmp++; if (lat !== 3 || low !== 2) begin n_bad++; $display("[TB] FAIL b2b_timing: got lat %0d low %0d expected 3/2", lat, low); end
    #1;
    n_cmp++; if (rd_dbg_data !== 8'hAA) begin n_bad++; $display("[TB] FAIL b2b_second: got %h expected AA", rd_dbg_data); end
    n_cmp++; if (status_flags !== ref_flags) begin n_bad++; $display("[TB] FAIL b2b_flags: got %b expected %b", status_flags, ref_flags); end
  endtask

  task automatic test_reset_mid_exec;
    @(negedge clk);
    host_write(2'd0, 8'h11);
    host_write(2'd1, 8'h22);
    cmd_valid = 1'b1; cmd_func = ADD; cmd_rs_a = 2'd0; cmd_rs_b = 2'd1; cmd_rd = 2'd2; cmd_wb_en = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (output_enable !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_exec_oe: got %b expected 1", output_enable); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_flags = 4'h0;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    n_cmp++; if (output_enable !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_idle: got oe %b ready %b expected 0/1", output_enable, cmd_ready); end
    n_cmp++; if (status_flags !== 4'h0) begin n_bad++; $display("[TB] FAIL abort_flags: got %b expected 0000", status_flags); end
    rd_dbg_addr = 2'd2; #1;
    n_cmp++; if (rd_dbg_data !== 8'h00) begin n_bad++; $display("[TB] FAIL abort_r2: got %h expected 00", rd_dbg_data); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_no_late_done: got %b expected 0", done); end
  endtask

  task automatic test_host_ignored;
    int lat, low;
    logic [11:0] e;
    @(negedge clk);
    host_write(2'd0, 8'h3C);
    host_write(2'd1, 8'h5A);
    e = alu_ref(AND, ref_regs[0], ref_regs[1]);
    cmd_valid = 1'b1; cmd_func = AND; cmd_rs_a = 2'd0; cmd_rs_b = 2'd1; cmd_rd = 2'd2; cmd_wb_en = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    host_wr_en = 1'b1; host_wr_addr = 2'd1; host_wr_data = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    host_wr_en = 1'b0;
    ref_regs[2] = e[7:0];
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("[TB] FAIL hostign_done: got %b expected 1", done); end
    rd_dbg_addr = 2'd1; #1;
    n_cmp++; if (rd_dbg_data !== 8'h5A) begin n_bad++; $display("[TB] FAIL hostign_r1: got %h expected 5A", rd_dbg_data); end
    rd_dbg_addr = 2'd2; #1;
    n_cmp++; if (rd_dbg_data !== 8'h18) begin n_bad++; $display("[TB] FAIL hostign_r2: got %h expected 18", rd_dbg_data); end
    @(negedge clk);
    host_wr_data = 8'hEE;
    run_cmd(XOR, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, lat, low);
    host_wr_en = 1'b1; host_wr_addr = 2'd3;
    cmd_valid = 1'b1; cmd_func = OR; cmd_rs_a = 2'd0; cmd_rs_b = 2'd0; cmd_rd = 2'd0; cmd_wb_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; host_wr_en = 1'b0;
    repeat (2) @(negedge clk);
    ref_flags = alu_ref(OR, ref_regs[0], ref_regs[0])[11:8];
    rd_dbg_addr = 2'd3; #1;
    n_cmp++; if (rd_dbg_data !== ref_regs[3]) begin n_bad++; $display("[TB] FAIL collide_r3: got %h expected %h", rd_dbg_data, ref_regs[3]); end
    n_cmp++; if (status_flags !== ref_flags) begin n_bad++; $display("[TB] FAIL collide_flags: got %b expected %b", status_flags, ref_flags); end
  endtask

  task automatic test_random;
    int lat, low;
    alu_func_e f;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) host_write(2'($urandom), 8'($urandom));
      f = alu_func_e'(3'($urandom_range(0, 7)));
      run_cmd(f, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 3) == 0), lat, low);
      n_cmp++; if (lat !== 3 || low !== 2) begin n_bad++; $display("[TB] FAIL rand%0d_timing: got lat %0d low %0d expected 3/2", n, lat, low); end
      n_cmp++; if (status_flags !== ref_flags) begin n_bad++; $display("[TB] FAIL rand%0d_flags: got %b expected %b", n, status_flags, ref_flags); end
      for (int i = 0; i < 4; i++) begin
        rd_dbg_addr = 2'(i); #1;
        n_cmp++; if (rd_dbg_data !== ref_regs[i]) begin n_bad++; $display("[TB] FAIL rand%0d_reg%0d: got %h expected %h", n, i, rd_dbg_data, ref_regs[i]); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_overflow();
    test_compare();
    test_back_to_back();
    test_reset_mid_exec();
    test_host_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Sequencing stage wrapped around the combinational `alu`.
- Holds a small register file and the status flag register.
- Accepts one ALU command at a time via valid/ready, then:
  - drives `operand_a`/`operand_b` from the register file,
  - enables the ALU output bus,
  - writes `alu_result` back to a destination register and latches Z/N/C/V.
- Sits between instruction decode (upstream) and the `alu` instance (downstream/feedback).

Parameters:
- DATA_W, 8, datapath width; must match the `alu` instance.
- NUM_REGS, 4, register file depth; power of two, minimum 2.
- REG_AW, $clog2(NUM_REGS), register index width; derived, not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_func  input  alu_func_e  ALU operation
- cmd_rs_a  input  REG_AW  source register for operand A
- cmd_rs_b  input  REG_AW  source register for operand B
- cmd_rd  input  REG_AW  destination register
- cmd_wb_en  input  1  1 = write result to rd; 0 = flags-only (compare)
- host_wr_en  input  1  direct register write
- host_wr_addr  input  REG_AW  direct write index
- host_wr_data  input  DATA_W  direct write data
- operand_a  output  DATA_W  to alu
- operand_b  output  DATA_W  to alu
- alu_func  output  alu_func_e  to alu
- output_enable  output  1  to alu tri-state enable
- alu_result  input  DATA_W  from alu (tri-state bus)
- zero_flag, negative_flag, carry_flag, signed_overflow  input  1 each  from alu
- status_flags  output  4  latched {V,C,N,Z}, bit3..bit0
- done  output  1  one-cycle pulse at writeback completion
- rd_dbg_addr  input  REG_AW  debug read index
- rd_dbg_data  output  DATA_W  combinational read of register rd_dbg_addr

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset is synchronous, active-high (`rst`).
  - On `rst`: state=IDLE; all registers=0; status_flags=0; operand_a/b=0; alu_func=ADD; output_enable=0; done=0; cmd_ready=1 in the cycle after reset.
- FSM states: IDLE, OPERAND, EXEC.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at a rising edge: latch func/rs_a/rs_b/rd/wb_en, go to OPERAND.
- OPERAND:
  - operand_a/operand_b registered from regs[rs_a]/regs[rs_b] at entry; alu_func driven from the latched func.
  - output_enable=0. Unconditionally go to EXEC.
- EXEC:
  - output_enable=1.
  - At the closing edge: if wb_en, regs[rd]<=alu_result; status_flags<={signed_overflow,carry_flag,negative_flag,zero_flag}.
  - done=1 in the following cycle (registered). Go to IDLE.
- Latency: accept edge to done high = 3 cycles. Throughput: one command per 3 cycles; cmd_ready is low in OPERAND and EXEC.
- alu_result is sampled only in EXEC; never sampled while output_enable=0 (bus is Z).
- operand_a/b and alu_func hold their values in IDLE after a command, until the next OPERAND.
- Host write:
  - Honoured only when state==IDLE and no command is accepted in the same edge; otherwise ignored (no queueing).
  - Host write and cmd acceptance in the same IDLE edge: command accepted, host write dropped.
- Hazards:
  - rs_a == rs_b == rd is legal: sources are read in OPERAND, write occurs at the end of EXEC.
  - Back-to-back commands see the prior result (writeback completes before the next OPERAND).
- Reset mid-operation (OPERAND or EXEC): abort with no writeback, no done pulse, flags cleared.
- cmd_* inputs are don't-care while cmd_ready=0.
- status_flags is unchanged by host writes.

Decomposition:
- alu_pkg gains:
  - `exec_state_e` {IDLE, OPERAND, EXEC};
  - `FLAG_Z`=0, `FLAG_N`=1, `FLAG_C`=2, `FLAG_V`=3 bit-index constants;
  - `status_flags_t` packed struct.
- alu_func_e is reused from alu_pkg.
- One sub-module: `reg_file` (NUM_REGS x DATA_W, two registered-read ports plus the combinational debug port, one write port with a single priority mux for EXEC writeback vs host write).

Test Plan:
- Host write r0=0x10, r1=0x20; cmd ADD rs_a=0 rs_b=1 rd=2 wb_en=1 -> done 3 cycles after accept; r2=0x30; status_flags=0000.
- r0=0x7F, r1=0x01, ADD rd=3 -> r3=0x80, status_flags=1010 (V=1, N=1).
- r0=0x30, r1=0x30, SUB wb_en=0 -> no register changes, Z=1; r0 still 0x30 via rd_dbg.
- Back-to-back: INV rs_a=0 rd=0 with r0=0xAA, then ADD r0+r0 -> r0=0x55 after the first command, 0xAA after the second; cmd_ready low for exactly 2 cycles per command.
- Assert rst during EXEC of ADD rd=2 -> r2=0, no done pulse, state IDLE, output_enable=0 next cycle.
- host_wr_en during OPERAND to r1=0xFF -> ignored, r1 unchanged.
